// File: rtl/data_mem_lsu_pkg.sv
// Shared encodings for the data-memory load/store unit.
package data_mem_lsu_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    READ,
    WRITE,
    RESP
  } lsu_state_e;

  typedef struct packed {
    logic       write;
    logic       uns;
    logic [1:0] size;
  } lsu_ctl_t;

  // Byte and half stores need the surrounding word read back first.
  function automatic logic is_subword(input logic [1:0] size);
    return (size == SIZE_BYTE) || (size == SIZE_HALF);
  endfunction

endpackage

// File: rtl/data_mem_lsu_data_align.sv
// Combinational lane alignment: load extension and sub-word store merge.
module lsu_data_align
  import data_mem_lsu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [1:0]   size,
  input  logic         uns,
  input  logic [N-1:0] raw,
  input  logic [N-1:0] buf_word,
  input  logic [N-1:0] wdata,
  output logic [N-1:0] load_data,
  output logic [N-1:0] store_data
);

  always_comb begin
    load_data  = raw;
    store_data = wdata;
    case (size)
      SIZE_BYTE: begin
        load_data  = {{(N-8){~uns & raw[7]}}, raw[7:0]};
        store_data = {buf_word[N-1:8], wdata[7:0]};
      end
      SIZE_HALF: begin
        load_data  = {{(N-16){~uns & raw[15]}}, raw[15:0]};
        store_data = {buf_word[N-1:16], wdata[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_lsu.sv
// Load/store unit: handshake, request latches and the access FSM in front of the data RAM.
module data_mem_lsu
  import data_mem_lsu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_write,
  input  logic [1:0]   req_size,
  input  logic         req_unsigned,
  input  logic [N-1:0] req_addr,
  input  logic [N-1:0] req_wdata,
  output logic         resp_valid,
  output logic [N-1:0] resp_rdata,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  output logic         mem_we,
  input  logic [N-1:0] mem_rdata
);

  lsu_state_e   state_q, state_d;
  lsu_ctl_t     ctl_q;
  logic [N-1:0] addr_q, wdata_q, wbuf_q, rdata_q;
  logic [N-1:0] load_ext, store_merge;
  logic         accept;

  assign accept     = req_valid && req_ready;
  assign mem_addr   = addr_q;
  assign resp_rdata = rdata_q;

  lsu_data_align #(.N(N)) u_align (
    .size       (ctl_q.size),
    .uns        (ctl_q.uns),
    .raw        (mem_rdata),
    .buf_word   (wbuf_q),
    .wdata      (wdata_q),
    .load_data  (load_ext),
    .store_data (store_merge)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctl_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wbuf_q  <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        ctl_q   <= '{write: req_write, uns: req_unsigned, size: req_size};
      end
      if (state_q == READ) wbuf_q  <= mem_rdata;
      if (state_q == LOAD) rdata_q <= load_ext;
    end
  end

  // All RAM-facing strobes come straight from the state register.
  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_we     = 1'b0;
    mem_wdata  = '0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (!req_write)              state_d = LOAD;
          else if (is_subword(req_size)) state_d = READ;
          else                         state_d = WRITE;
        end
      end
      LOAD:  state_d = RESP;
      READ:  state_d = WRITE;
      WRITE: begin
        mem_we    = 1'b1;
        mem_wdata = store_merge;
        state_d   = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_data_mem_lsu.sv
// Self-checking bench for data_mem_lsu with a byte-array RAM and a byte-level reference model.
module tb_data_mem_lsu;
  localparam int N      = 32;
  localparam int RAM_SZ = 1024;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0, req_write = 1'b0, req_unsigned = 1'b0;
  logic [1:0]   req_size = 2'b00;
  logic [N-1:0] req_addr = '0, req_wdata = '0;
  logic         req_ready, resp_valid, mem_we;
  logic [N-1:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  data_mem_lsu #(.N(N)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_we       (mem_we),
    .mem_rdata    (mem_rdata)
  );

  // RAM: combinational little-endian read, full-word write, per-byte wrap.
  logic [7:0] ram [RAM_SZ];
  logic       ram_init = 1'b1;

  assign mem_rdata = {ram[mem_addr[9:0] + 10'd3], ram[mem_addr[9:0] + 10'd2],
                      ram[mem_addr[9:0] + 10'd1], ram[mem_addr[9:0]]};

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < RAM_SZ; i++) ram[i] <= 8'hAA;
    end else if (mem_we) begin
      for (int i = 0; i < 4; i++) ram[10'(mem_addr[9:0] + 10'(i))] <= mem_wdata[8*i +: 8];
    end
  end

  // Reference model: an independent byte array updated per architectural store.
  logic [7:0]  ref_mem [RAM_SZ];
  logic [31:0] last_rdata = '0;
  int          tests = 0, fails = 0;

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] s, input logic u, input logic [31:0] a);
    int n = nbytes(s);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[10'(a + 32'(i))];
    if (!u && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
    return v;
  endfunction

  task automatic model_store(input logic [1:0] s, input logic [31:0] a, input logic [31:0] wd);
    for (int i = 0; i < nbytes(s); i++) ref_mem[10'(a + 32'(i))] = wd[8*i +: 8];
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // One full transaction starting from the settled point of an IDLE cycle.
  task automatic do_req(input logic w, input logic [1:0] s, input logic u, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] exp_rd, input int exp_lat,
                        input string tag);
    int   lat = 0, we_cnt = 0, guard = 0;
    logic wd_bad = 1'b0;
    while (!req_ready && guard < 20) begin step(); guard++; end
    check({tag, " ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = w; req_size = s; req_unsigned = u; req_addr = a; req_wdata = wd;
    step();
    req_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (resp_valid) begin lat = c; break; end
      if (mem_we) we_cnt++;
      else if (mem_wdata != '0) wd_bad = 1'b1;
      step();
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " we_pulses"}, 32'(we_cnt), w ? 32'd1 : 32'd0);
    check({tag, " idle_wdata"}, 32'(wd_bad), 32'd0);
    check({tag, " rdata"}, resp_rdata, w ? last_rdata : exp_rd);
    if (w) model_store(s, a, wd);
    else   last_rdata = exp_rd;
    step();
  endtask

  typedef struct {
    logic        w;
    logic [1:0]  s;
    logic        u;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  initial begin
    vec_t tbl[$];
    int   seen;

    for (int i = 0; i < RAM_SZ; i++) ref_mem[i] = 8'hAA;
    tbl.push_back('{1'b0, 2'b00, 1'b0, 32'd0,    32'h0,        32'hFFFF_FFAA, 2});
    tbl.push_back('{1'b0, 2'b00, 1'b1, 32'd0,    32'h0,        32'h0000_00AA, 2});
    tbl.push_back('{1'b1, 2'b10, 1'b0, 32'd4,    32'h1122_3344, 32'h0,        2});
    tbl.push_back('{1'b1, 2'b00, 1'b0, 32'd5,    32'h1234_565C, 32'h0,        3});
    tbl.push_back('{1'b0, 2'b10, 1'b0, 32'd4,    32'h0,        32'h1122_5C44, 2});
    tbl.push_back('{1'b0, 2'b00, 1'b0, 32'd5,    32'h0,        32'h0000_005C, 2});
    tbl.push_back('{1'b0, 2'b01, 1'b0, 32'd5,    32'h0,        32'h0000_225C, 2});
    tbl.push_back('{1'b1, 2'b01, 1'b0, 32'd1022, 32'h7777_BEEF, 32'h0,        3});
    tbl.push_back('{1'b0, 2'b10, 1'b0, 32'd1022, 32'h0,        32'hAAAA_BEEF, 2});
    tbl.push_back('{1'b0, 2'b01, 1'b1, 32'd0,    32'h0,        32'h0000_AAAA, 2});
    tbl.push_back('{1'b0, 2'b01, 1'b0, 32'd1022, 32'h0,        32'hFFFF_BEEF, 2});
    tbl.push_back('{1'b1, 2'b11, 1'b0, 32'd8,    32'hCAFE_F00D, 32'h0,        2});
    tbl.push_back('{1'b0, 2'b10, 1'b0, 32'd8,    32'h0,        32'hCAFE_F00D, 2});

    // Reset state
    step(); step();
    check("rst req_ready", 32'(req_ready), 32'd1);
    check("rst resp_valid", 32'(resp_valid), 32'd0);
    check("rst mem_we", 32'(mem_we), 32'd0);
    check("rst resp_rdata", resp_rdata, 32'h0);
    check("rst mem_addr", mem_addr, 32'h0);
    ram_init = 1'b0;
    #4 rst_n = 1'b1;
    step();

    foreach (tbl[k])
      do_req(tbl[k].w, tbl[k].s, tbl[k].u, tbl[k].a, tbl[k].wd, tbl[k].exp, tbl[k].lat,
             $sformatf("vec%0d", k));

    // Request held valid through a sub-word store: must wait for IDLE.
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'd200; req_wdata = 32'hDEAD_BE77;
    step();
    req_write = 1'b0; req_size = 2'b10; req_addr = 32'd300;
    for (int c = 1; c <= 3; c++) begin
      check($sformatf("hold c%0d ready", c), 32'(req_ready), 32'd0);
      check($sformatf("hold c%0d resp", c), 32'(resp_valid), (c == 3) ? 32'd1 : 32'd0);
      step();
    end
    check("hold idle ready", 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
    check("hold load busy", 32'(resp_valid), 32'd0);
    step();
    check("hold load resp", 32'(resp_valid), 32'd1);
    check("hold load rdata", resp_rdata, 32'hAAAA_AAAA);
    model_store(2'b00, 32'd200, 32'hDEAD_BE77);
    last_rdata = 32'hAAAA_AAAA;
    step();
    do_req(1'b0, 2'b10, 1'b0, 32'd200, 32'h0, 32'hAAAA_AA77, 2, "hold verify");

    // Reset during READ of a byte store aborts the write.
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_addr = 32'd100; req_wdata = 32'h33;
    step();
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("abort ready", 32'(req_ready), 32'd1);
    check("abort we", 32'(mem_we), 32'd0);
    check("abort resp", 32'(resp_valid), 32'd0);
    #3 rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (mem_we || resp_valid) seen++;
    end
    check("abort quiet", 32'(seen), 32'd0);
    check("abort rdata", resp_rdata, 32'h0);
    last_rdata = 32'h0;
    do_req(1'b0, 2'b10, 1'b0, 32'd100, 32'h0, 32'hAAAA_AAAA, 2, "abort mem");

    // Randomized traffic against the byte-level model, biased toward the wrap point.
    for (int t = 0; t < 60; t++) begin
      logic        w, u;
      logic [1:0]  s;
      logic [31:0] a, wd;
      w  = 1'($urandom_range(0, 1));
      u  = 1'($urandom_range(0, 1));
      s  = 2'($urandom_range(0, 3));
      a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1020, 1023)) : $urandom();
      wd = $urandom();
      do_req(w, s, u, a, wd, w ? 32'h0 : model_load(s, u, a),
             (w && s < 2'b10) ? 3 : 2, $sformatf("rnd%0d", t));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/data_mem_lsu.md
Name: data_mem_lsu

Overview:
- Load/store unit between the CPU datapath and the byte-addressed, 32-bit-port, little-endian data RAM.
- The RAM reads combinationally and writes a full 4-byte word on the clock edge.
- This block adds byte/halfword/word loads with sign or zero extension.
- It also adds sub-word stores, implemented as a read-modify-write sequence, so neighbouring bytes are never clobbered.
- Handshake: valid/ready request and a one-cycle response pulse; the CPU stalls while req_ready is low.

Parameters:
- N, 32, datapath and address width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  CPU request present.
- req_ready  out  1  block idle; request accepted when req_valid && req_ready.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend; ignored for stores.
- req_addr  in  N  byte address, any alignment.
- req_wdata  in  N  store data, right-justified.
- resp_valid  out  1  one-cycle pulse: access complete.
- resp_rdata  out  N  extended load result; held until the next load completes.
- mem_addr  out  N  to RAM addr.
- mem_wdata  out  N  to RAM write_data.
- mem_we  out  1  to RAM write_enable.
- mem_rdata  in  N  from RAM data (combinational).

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE; latched addr/wdata/size/flags = 0; word buffer = 0; resp_rdata = 0.
  - Outputs during reset: resp_valid 0, mem_we 0, req_ready 1.
- Registered states: IDLE, LOAD, READ, WRITE, RESP.
  - IDLE: req_ready = 1. On accept, latch req_addr, req_wdata, req_size, req_unsigned, req_write. Next state:
    - load -> LOAD
    - word store -> WRITE
    - byte/half store -> READ
  - LOAD: mem_addr = latched addr; capture extended mem_rdata into resp_rdata; -> RESP.
    - byte: bits[7:0]; half: bits[15:0].
    - Sign-extend from bit 7/15 unless unsigned.
  - READ: mem_addr = latched addr; capture mem_rdata into the word buffer; -> WRITE.
  - WRITE: mem_we = 1, mem_addr = latched addr; -> RESP. mem_wdata by size:
    - word: latched wdata.
    - half: {buf[31:16], wdata[15:0]}.
    - byte: {buf[31:8], wdata[7:0]}.
  - RESP: resp_valid = 1 for exactly one cycle; -> IDLE.
- Outputs outside the listed states:
  - req_ready = 0 in every state except IDLE; req_valid is ignored while not ready.
  - mem_we = 0 and mem_wdata = 0 outside WRITE.
  - mem_addr = latched addr in all states.
- Latency, counting the accept cycle as cycle 0; resp_valid asserts in:
  - load: cycle 2.
  - word store: cycle 2.
  - sub-word store: cycle 3.
  - Next accept is possible in the cycle after resp_valid.
- Store timing: the store is visible in the RAM from the cycle after WRITE, i.e. by the time resp_valid is high.
- Addresses are passed unmodified; the RAM applies its modulo-SIZE wrap per byte. Unaligned and wrapping accesses need no special handling here.
- Stores leave resp_rdata unchanged.
- Reset mid-operation aborts immediately: no mem_we pulse and no resp_valid after reset release; the block returns to IDLE.
- mem_we, req_ready, resp_valid and mem_wdata are decoded from state, so they are glitch-free relative to clk edges.

Decomposition:
- Shared package holds:
  - size encodings SIZE_BYTE = 2'b00, SIZE_HALF = 2'b01, SIZE_WORD = 2'b10.
  - state encodings IDLE/LOAD/READ/WRITE/RESP.
- Sub-module lsu_data_align (combinational) provides load extension (size, unsigned, raw word -> result) and store merge (size, buffer, wdata -> merged word).
- The FSM, latches and handshake stay in data_mem_lsu.

Test Plan:
- Reset release, load byte signed at addr 0 (RAM reset fill 0xAA) -> resp_valid in cycle 2, resp_rdata = 0xFFFFFFAA. Same load unsigned -> 0x000000AA.
- Word store 0x11223344 at addr 4, then byte store 0x5C at addr 5, then word load at 4:
  - byte store -> resp_valid in cycle 3, exactly one mem_we pulse.
  - word load -> 0x11225C44.
- Half store 0xBEEF at addr 1022 (RAM SIZE 1024), then word load at 1022 -> 0xAAAABEEF; bytes 0 and 1 remain 0xAA. Half load signed at 1022 -> 0xFFFFBEEF.
- req_valid held high with a different address during the READ/WRITE states of a sub-word store:
  - req_ready = 0 throughout; the second request is accepted only in the IDLE cycle after resp_valid.
  - Both accesses complete correctly.
- rst_n pulsed low during READ of a byte store:
  - mem_we never asserts, resp_valid never asserts, req_ready = 1 immediately.
  - Memory remains 0xAA.
- req_size = 11 store of 0xCAFEF00D at addr 8, then word load -> 0xCAFEF00D, single WRITE (no READ state).
